// File: rtl/trap_sequencer_if.sv
// Trap sequencer bundle: CPU/interrupt-controller requests in,
// CSR event, latched trap info and CPU control out.
interface trap_sequencer_if #(
  parameter int XLEN = 32
);
  logic            insn_boundary;
  logic [XLEN-1:0] cur_pc;
  logic            exc_req;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic            irq_ssi;
  logic            irq_msi;
  logic            irq_sti;
  logic            irq_mti;
  logic            irq_sei;
  logic            irq_mei;
  logic            irq_pending_any;
  logic            wfi_req;
  logic            redirect_done;
  logic            trap_start;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_badaddr;
  logic            redirect;
  logic            cpu_stall;
  logic            wfi_event;
  logic            busy;

  modport master (
    output insn_boundary, cur_pc,
    output exc_req, exc_code, exc_pc, exc_tval,
    output irq_ssi, irq_msi, irq_sti,
    output irq_mti, irq_sei, irq_mei,
    output irq_pending_any, wfi_req,
    output redirect_done,
    input  trap_start, trap_cause,
    input  trap_pc, trap_badaddr,
    input  redirect, cpu_stall,
    input  wfi_event, busy
  );

  modport slave (
    input  insn_boundary, cur_pc,
    input  exc_req, exc_code, exc_pc, exc_tval,
    input  irq_ssi, irq_msi, irq_sti,
    input  irq_mti, irq_sei, irq_mei,
    input  irq_pending_any, wfi_req,
    input  redirect_done,
    output trap_start, trap_cause,
    output trap_pc, trap_badaddr,
    output redirect, cpu_stall,
    output wfi_event, busy
  );
endinterface

// File: rtl/trap_sequencer.sv
// Trap entry sequencer: picks exception or prioritised irq,
// pulses the CSR event, stalls until redirect, handles WFI.
module trap_sequencer #(
  parameter int         XLEN            = 32,
  parameter logic [5:0] IRQ_ENABLE_MASK = 6'b111111
) (
  input logic            clk,
  input logic            reset,
  trap_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ENTER, REDIRECT, SLEEP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [5:0]      irq_en;
  logic            irq_hit;
  logic            take;
  logic [4:0]      irq_code;
  logic [XLEN-1:0] sel_cause;
  logic [XLEN-1:0] sel_pc;
  logic [XLEN-1:0] sel_tval;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] tval_q;
  logic            wfi_q;

  assign irq_en = IRQ_ENABLE_MASK & {
    bus.irq_mei, bus.irq_sei, bus.irq_mti,
    bus.irq_sti, bus.irq_msi, bus.irq_ssi
  };
  assign irq_hit = bus.insn_boundary && (irq_en != 6'd0);
  assign take = !reset && (state == IDLE)
    && (bus.exc_req || irq_hit);

  // mei > msi > mti > sei > ssi > sti
  always_comb begin
    irq_code = 5'd0;
    if (irq_en[5])      irq_code = 5'd11;
    else if (irq_en[1]) irq_code = 5'd3;
    else if (irq_en[3]) irq_code = 5'd7;
    else if (irq_en[4]) irq_code = 5'd9;
    else if (irq_en[0]) irq_code = 5'd1;
    else if (irq_en[2]) irq_code = 5'd5;
  end

  always_comb begin
    sel_cause = '0;
    sel_pc    = bus.cur_pc;
    sel_tval  = '0;
    if (bus.exc_req) begin
      sel_cause[3:0] = bus.exc_code;
      sel_pc         = bus.exc_pc;
      sel_tval       = bus.exc_tval;
    end else begin
      sel_cause[XLEN-1] = 1'b1;
      sel_cause[4:0]    = irq_code;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (take)             state_nx = ENTER;
        else if (bus.wfi_req) state_nx = SLEEP;
      end
      ENTER:    state_nx = REDIRECT;
      REDIRECT: if (bus.redirect_done) state_nx = IDLE;
      SLEEP:    if (bus.irq_pending_any) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cause_q <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
      wfi_q   <= 1'b0;
    end else begin
      state <= state_nx;
      wfi_q <= (state == SLEEP) && bus.irq_pending_any;
      if (take) begin
        cause_q <= sel_cause;
        pc_q    <= sel_pc;
        tval_q  <= sel_tval;
      end
    end
  end

  assign bus.trap_start   = (state == ENTER);
  assign bus.redirect     = (state == REDIRECT);
  assign bus.busy         = (state != IDLE);
  assign bus.cpu_stall    = (state != IDLE) || take;
  assign bus.wfi_event    = wfi_q;
  assign bus.trap_cause   = cause_q;
  assign bus.trap_pc      = pc_q;
  assign bus.trap_badaddr = tval_q;
endmodule

// File: tb/tb_trap_sequencer.sv
// Randomised and directed checks of trap_sequencer against a
// cycle-level behavioural model; two DUTs differ in irq mask.
module tb_trap_sequencer;
  localparam int         XLEN   = 32;
  localparam logic [5:0] MASK_A = 6'b111111;
  localparam logic [5:0] MASK_B = 6'b011111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        insn_boundary = 1'b0;
  logic [31:0] cur_pc = '0;
  logic        exc_req = 1'b0;
  logic [3:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_tval = '0;
  logic [5:0]  irqs = '0;
  logic        irq_pending_any = 1'b0;
  logic        wfi_req = 1'b0;
  logic        redirect_done = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  trap_sequencer_if #(.XLEN(XLEN)) ia ();
  trap_sequencer_if #(.XLEN(XLEN)) ib ();

  trap_sequencer #(
    .XLEN(XLEN), .IRQ_ENABLE_MASK(MASK_A)
  ) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));

  trap_sequencer #(
    .XLEN(XLEN), .IRQ_ENABLE_MASK(MASK_B)
  ) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

  // irqs order: {mei, sei, mti, sti, msi, ssi}
  assign ia.insn_boundary = insn_boundary;
  assign ia.cur_pc = cur_pc;
  assign ia.exc_req = exc_req;
  assign ia.exc_code = exc_code;
  assign ia.exc_pc = exc_pc;
  assign ia.exc_tval = exc_tval;
  assign ia.irq_mei = irqs[5];
  assign ia.irq_sei = irqs[4];
  assign ia.irq_mti = irqs[3];
  assign ia.irq_sti = irqs[2];
  assign ia.irq_msi = irqs[1];
  assign ia.irq_ssi = irqs[0];
  assign ia.irq_pending_any = irq_pending_any;
  assign ia.wfi_req = wfi_req;
  assign ia.redirect_done = redirect_done;
  assign ib.insn_boundary = insn_boundary;
  assign ib.cur_pc = cur_pc;
  assign ib.exc_req = exc_req;
  assign ib.exc_code = exc_code;
  assign ib.exc_pc = exc_pc;
  assign ib.exc_tval = exc_tval;
  assign ib.irq_mei = irqs[5];
  assign ib.irq_sei = irqs[4];
  assign ib.irq_mti = irqs[3];
  assign ib.irq_sti = irqs[2];
  assign ib.irq_msi = irqs[1];
  assign ib.irq_ssi = irqs[0];
  assign ib.irq_pending_any = irq_pending_any;
  assign ib.wfi_req = wfi_req;
  assign ib.redirect_done = redirect_done;

  // Model: age = cycles since a trap was accepted (-1: none)
  logic [5:0]  masks [2] = '{MASK_A, MASK_B};
  int          age [2] = '{-1, -1};
  bit          asleep [2] = '{0, 0};
  bit          woke [2] = '{0, 0};
  logic [31:0] m_cause [2] = '{32'h0, 32'h0};
  logic [31:0] m_pc [2] = '{32'h0, 32'h0};
  logic [31:0] m_bad [2] = '{32'h0, 32'h0};

  function automatic int pick(logic [5:0] lines, logic [5:0] mask);
    int order [6] = '{11, 3, 7, 9, 1, 5};
    for (int i = 0; i < 6; i++) begin
      int b;
      b = (order[i] - 1) / 2;
      if (lines[b] && mask[b]) return order[i];
    end
    return -1;
  endfunction

  task automatic check(input string name, input int d,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d got %h want %h @%0t",
               name, d, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int code;
      bit w;
      code = pick(irqs, masks[d]);
      w = 1'b0;
      if (reset) begin
        age[d] = -1;
        asleep[d] = 1'b0;
        m_cause[d] = '0;
        m_pc[d] = '0;
        m_bad[d] = '0;
      end else if (age[d] >= 0) begin
        if (age[d] >= 2 && redirect_done) age[d] = -1;
        else age[d] = age[d] + 1;
      end else if (asleep[d]) begin
        if (irq_pending_any) begin
          asleep[d] = 1'b0;
          w = 1'b1;
        end
      end else if (exc_req) begin
        m_cause[d] = {28'd0, exc_code};
        m_pc[d] = exc_pc;
        m_bad[d] = exc_tval;
        age[d] = 1;
      end else if (insn_boundary && code >= 0) begin
        m_cause[d] = 32'h8000_0000 | 32'(code);
        m_pc[d] = cur_pc;
        m_bad[d] = '0;
        age[d] = 1;
      end else if (wfi_req) begin
        asleep[d] = 1'b1;
      end
      woke[d] = w;
    end
  endtask

  task automatic compare_dut(
    input int d, input logic ts, input logic rd,
    input logic st, input logic we, input logic bz,
    input logic [31:0] c, input logic [31:0] p,
    input logic [31:0] b
  );
    int   code;
    logic e_busy;
    logic e_take;
    code = pick(irqs, masks[d]);
    e_busy = !reset && (age[d] >= 0 || asleep[d]);
    e_take = !reset && !e_busy
      && (exc_req || (insn_boundary && code >= 0));
    check("trap_start", d, 32'(ts), 32'(!reset && age[d] == 1));
    check("redirect", d, 32'(rd), 32'(!reset && age[d] >= 2));
    check("busy", d, 32'(bz), 32'(e_busy));
    check("cpu_stall", d, 32'(st), 32'(e_busy || e_take));
    check("wfi_event", d, 32'(we), 32'(!reset && woke[d]));
    check("trap_cause", d, c, reset ? 32'h0 : m_cause[d]);
    check("trap_pc", d, p, reset ? 32'h0 : m_pc[d]);
    check("trap_badaddr", d, b, reset ? 32'h0 : m_bad[d]);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      #2;
      compare_dut(0, ia.trap_start, ia.redirect, ia.cpu_stall,
                  ia.wfi_event, ia.busy, ia.trap_cause,
                  ia.trap_pc, ia.trap_badaddr);
      compare_dut(1, ib.trap_start, ib.redirect, ib.cpu_stall,
                  ib.wfi_event, ib.busy, ib.trap_cause,
                  ib.trap_pc, ib.trap_badaddr);
    end
  end

  task automatic quiet();
    insn_boundary = 1'b0;
    exc_req = 1'b0;
    irqs = '0;
    irq_pending_any = 1'b0;
    wfi_req = 1'b0;
    redirect_done = 1'b0;
  endtask

  // Called in the ENTER cycle; leaves the DUT back in IDLE.
  task automatic finish_redirect();
    @(negedge clk);
    redirect_done = 1'b1;
    @(negedge clk);
    redirect_done = 1'b0;
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("rst_busy", 0, 32'(ia.busy), 32'h0);
    check("rst_cause", 0, ia.trap_cause, 32'h0);
    reset = 1'b0;

    @(negedge clk);
    exc_req = 1'b1;
    exc_code = 4'd13;
    exc_pc = 32'h8000_0040;
    exc_tval = 32'hC000_1000;
    @(negedge clk);
    exc_req = 1'b0;
    #3;
    check("exc_start", 0, 32'(ia.trap_start), 32'h1);
    check("exc_cause", 0, ia.trap_cause, 32'h0000_000D);
    check("exc_pc", 0, ia.trap_pc, 32'h8000_0040);
    check("exc_bad", 0, ia.trap_badaddr, 32'hC000_1000);
    @(negedge clk);
    #3;
    check("exc_once", 0, 32'(ia.trap_start), 32'h0);
    check("exc_redir", 0, 32'(ia.redirect), 32'h1);
    repeat (3) @(negedge clk);
    redirect_done = 1'b1;
    @(negedge clk);
    redirect_done = 1'b0;
    #3;
    check("exc_idle", 0, 32'(ia.busy), 32'h0);
    check("exc_noredir", 0, 32'(ia.redirect), 32'h0);

    @(negedge clk);
    irqs = 6'b001001;
    insn_boundary = 1'b1;
    cur_pc = 32'h8000_1000;
    @(negedge clk);
    irqs = '0;
    #3;
    check("irq_start", 0, 32'(ia.trap_start), 32'h1);
    check("irq_cause", 0, ia.trap_cause, 32'h8000_0007);
    check("irq_pc", 0, ia.trap_pc, 32'h8000_1000);
    check("irq_bad", 0, ia.trap_badaddr, 32'h0);
    finish_redirect();

    irqs = 6'b001001;
    insn_boundary = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #3;
      check("nobound_start", 0, 32'(ia.trap_start), 32'h0);
    end
    irqs = '0;

    @(negedge clk);
    exc_req = 1'b1;
    exc_code = 4'd2;
    irqs = 6'b100000;
    insn_boundary = 1'b1;
    @(negedge clk);
    exc_req = 1'b0;
    #3;
    check("exc_irq_cause", 0, ia.trap_cause, 32'h0000_0002);
    finish_redirect();
    @(negedge clk);
    #3;
    check("mei_start", 0, 32'(ia.trap_start), 32'h1);
    check("mei_cause", 0, ia.trap_cause, 32'h8000_000B);
    @(negedge clk);
    #3;
    check("rst_redir_pre", 0, 32'(ia.redirect), 32'h1);
    reset = 1'b1;
    irqs = '0;
    #1;
    check("rst_redir", 0, 32'(ia.redirect), 32'h0);
    check("rst_start", 0, 32'(ia.trap_start), 32'h0);
    check("rst_idle", 0, 32'(ia.busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #3;
    check("rst_nopulse", 0, 32'(ia.trap_start), 32'h0);

    @(negedge clk);
    wfi_req = 1'b1;
    @(negedge clk);
    wfi_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #3;
      check("sleep_stall", 0, 32'(ia.cpu_stall), 32'h1);
      @(negedge clk);
    end
    irq_pending_any = 1'b1;
    irqs = 6'b000100;
    insn_boundary = 1'b1;
    @(negedge clk);
    irq_pending_any = 1'b0;
    #3;
    check("wake_pulse", 0, 32'(ia.wfi_event), 32'h1);
    check("wake_idle", 0, 32'(ia.busy), 32'h0);
    @(negedge clk);
    irqs = '0;
    #3;
    check("wake_once", 0, 32'(ia.wfi_event), 32'h0);
    check("sti_cause", 0, ia.trap_cause, 32'h8000_0005);
    finish_redirect();

    @(negedge clk);
    irqs = 6'b100000;
    insn_boundary = 1'b1;
    @(negedge clk);
    #3;
    check("mask_start", 1, 32'(ib.trap_start), 32'h0);
    @(negedge clk);
    #3;
    check("mask_idle", 1, 32'(ib.busy), 32'h0);
    irqs = 6'b110000;
    @(negedge clk);
    irqs = '0;
    #3;
    check("sei_start", 1, 32'(ib.trap_start), 32'h1);
    check("sei_cause", 1, ib.trap_cause, 32'h8000_0009);
    @(negedge clk);
    redirect_done = 1'b1;
    @(negedge clk);
    quiet();

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(99) == 0);
      insn_boundary = ($urandom_range(9) < 7);
      cur_pc = $urandom;
      exc_req = ($urandom_range(9) == 0);
      exc_code = 4'($urandom);
      exc_pc = $urandom;
      exc_tval = $urandom;
      for (int k = 0; k < 6; k++)
        irqs[k] = ($urandom_range(11) == 0);
      irq_pending_any = ($urandom_range(4) == 0);
      wfi_req = ($urandom_range(9) == 0);
      redirect_done = ($urandom_range(9) < 4);
      @(negedge clk);
    end
    reset = 1'b0;
    quiet();
    repeat (4) @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
